// File: rtl/reg_cmd_ctrl_pkg.sv
// Shared definitions for the register-file command controller.
// Pure declarations; no logic, no latency.
// Command codes, default widths and the controller FSM state encoding.
package reg_cmd_ctrl_pkg;

  // Default widths: one byte on the UART side, 16 registers behind the port.
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  // Frame opcodes carried in the first byte of every host frame.
  localparam logic [7:0] WR_CMD = 8'hAA;  // cmd, addr, data
  localparam logic [7:0] RD_CMD = 8'hBB;  // cmd, addr

  // Controller states. WR_ACK is only reachable when write echo is built in.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5,
    TX_HOLD = 3'd6,
    WR_ACK  = 3'd7
  } state_t;

endpackage

// File: rtl/reg_cmd_ctrl.sv
// Purpose: decode UART write/read byte frames into register-file strobes and return read data to UART TX.
// Latency: WrEn/RdEn one cycle after the last frame byte; read data captured one cycle after RdData_Valid.
// Backpressure: TX request held while TX_Busy=1; bytes arriving outside a frame-accepting state are dropped.
// Build option: define REG_CMD_WR_ACK_EN to echo every written byte back through the TX path.
module reg_cmd_ctrl
  import reg_cmd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  input  logic                  TX_Busy,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  Cmd_Err
);

  // Opcodes resized to the byte width so the compares stay width-clean.
  localparam logic [DATA_WIDTH-1:0] WR_CMD_W = DATA_WIDTH'(WR_CMD);
  localparam logic [DATA_WIDTH-1:0] RD_CMD_W = DATA_WIDTH'(RD_CMD);

  state_t                  state_q;
  state_t                  state_nxt;

  // D-side of the registered outputs; every output leaves the block from a flop.
  logic                    wr_en_nxt;
  logic                    rd_en_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [DATA_WIDTH-1:0]   wr_data_nxt;
  logic [DATA_WIDTH-1:0]   tx_data_nxt;
  logic                    tx_vld_nxt;
  logic                    cmd_err_nxt;

  // Convenience decodes of the incoming byte.
  logic                    rx_is_wr;
  logic                    rx_is_rd;

  assign rx_is_wr = (RX_P_DATA == WR_CMD_W);
  assign rx_is_rd = (RX_P_DATA == RD_CMD_W);

  // State register; reset anywhere in a frame drops back to IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state decode: frame parsing, read wait and the two-step TX handshake.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (rx_is_wr) begin
            state_nxt = WR_ADDR;
          end else if (rx_is_rd) begin
            state_nxt = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          state_nxt = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
`ifdef REG_CMD_WR_ACK_EN
          state_nxt = WR_ACK;
`else
          state_nxt = IDLE;
`endif
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (RdData_Valid) begin
          state_nxt = TX_SEND;
        end
      end
      TX_SEND: begin
        // Only request once the serializer is free.
        if (!TX_Busy) begin
          state_nxt = TX_HOLD;
        end
      end
      TX_HOLD: begin
        // Wait until the serializer shows it took the byte before accepting
        // another frame, so a second request cannot slip in behind the first.
        if (TX_Busy) begin
          state_nxt = IDLE;
        end
      end
      WR_ACK: begin
`ifdef REG_CMD_WR_ACK_EN
        state_nxt = TX_SEND;
`else
        state_nxt = IDLE;
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode: strobes default low, captured fields hold their last value.
  always_comb begin
    wr_en_nxt   = 1'b0;
    rd_en_nxt   = 1'b0;
    tx_vld_nxt  = 1'b0;
    cmd_err_nxt = 1'b0;
    addr_nxt    = Address;
    wr_data_nxt = WrData;
    tx_data_nxt = TX_P_DATA;
    case (state_q)
      IDLE: begin
        // Anything that is not a known opcode is flagged and discarded.
        if (RX_D_VLD && !rx_is_wr && !rx_is_rd) begin
          cmd_err_nxt = 1'b1;
        end
      end
      WR_ADDR: begin
        // Upper address bits are ignored; the register file is small.
        if (RX_D_VLD) begin
          addr_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_en_nxt   = 1'b1;
          wr_data_nxt = RX_P_DATA;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_nxt = 1'b1;
        end
      end
      RD_WAIT: begin
        if (RdData_Valid) begin
          tx_data_nxt = RdData;
        end
      end
      TX_SEND: begin
        if (!TX_Busy) begin
          tx_vld_nxt = 1'b1;
        end
      end
      WR_ACK: begin
`ifdef REG_CMD_WR_ACK_EN
        // WrData already holds the byte written in the previous cycle.
        tx_data_nxt = WrData;
`endif
      end
      default: begin
      end
    endcase
  end

  // Output registers; all cleared by reset so no stale strobe survives an abort.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      Cmd_Err   <= 1'b0;
    end else begin
      WrEn      <= wr_en_nxt;
      RdEn      <= rd_en_nxt;
      Address   <= addr_nxt;
      WrData    <= wr_data_nxt;
      TX_P_DATA <= tx_data_nxt;
      TX_D_VLD  <= tx_vld_nxt;
      Cmd_Err   <= cmd_err_nxt;
    end
  end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
`timescale 1ns/1ps
module tb_reg_cmd_ctrl;
  import reg_cmd_ctrl_pkg::*;

`ifdef REG_CMD_WR_ACK_EN
  localparam int ACK = 1;
`else
  localparam int ACK = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic [7:0] RdData = 8'h00;
  logic       RdData_Valid = 1'b0;
  logic       TX_Busy;
  logic       WrEn, RdEn, TX_D_VLD, Cmd_Err;
  logic [3:0] Address;
  logic [7:0] WrData, TX_P_DATA;

  logic       model_busy = 1'b0;
  logic       force_busy = 1'b0;
  assign TX_Busy = model_busy | force_busy;

  int errors = 0;
  int checks = 0;

  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, tx_cnt = 0, both_cnt = 0;
  logic [7:0] last_tx = 8'h00;
  int rd_lat = 1;
  int rd_pend = 0;
  int busy_cnt = 0;
  logic [7:0] rd_val = 8'h00;
  logic [7:0] mem [16];

  int base_tx, base_wr, base_rd, base_err;

  reg_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .TX_Busy(TX_Busy),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .Cmd_Err(Cmd_Err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_tx(input int target, input string tag);
    int n;
    n = 0;
    while (tx_cnt < target && n < 60) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(tx_cnt >= target), 32'd1);
  endtask

  // Register file and TX serializer models plus strobe monitor, sampled just after each edge.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    forever begin
      @(posedge CLK);
      #1;
      if (WrEn) begin
        wr_cnt++;
        mem[Address] = WrData;
      end
      if (RdEn) rd_cnt++;
      if (WrEn && RdEn) both_cnt++;
      if (Cmd_Err) err_cnt++;
      RdData_Valid = 1'b0;
      if (rd_pend > 0) begin
        rd_pend--;
        if (rd_pend == 0) begin
          RdData_Valid = 1'b1;
          RdData = rd_val;
        end
      end
      if (RdEn) begin
        rd_val = mem[Address];
        if (rd_lat <= 1) begin
          RdData_Valid = 1'b1;
          RdData = rd_val;
        end else begin
          rd_pend = rd_lat - 1;
        end
      end
      if (busy_cnt > 0) busy_cnt--;
      if (TX_D_VLD) begin
        tx_cnt++;
        last_tx = TX_P_DATA;
        busy_cnt = 4;
      end
      model_busy = (busy_cnt > 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    settle(3);
    chk("rst_wren", WrEn, 0);
    chk("rst_rden", RdEn, 0);
    chk("rst_txvld", TX_D_VLD, 0);
    chk("rst_cmderr", Cmd_Err, 0);
    chk("rst_addr", Address, 0);
    chk("rst_wrdata", WrData, 0);
    chk("rst_txdata", TX_P_DATA, 0);
    RST = 1'b1;
    settle(2);

    // Write frame AA,05,3C with gaps
    send_byte(8'hAA); settle(2);
    send_byte(8'h05); settle(1);
    send_byte(8'h3C);
    chk("wr_pulse", WrEn, 1);
    chk("wr_addr", Address, 5);
    chk("wr_data", WrData, 8'h3C);
    chk("wr_no_rd", RdEn, 0);
    @(negedge CLK);
    chk("wr_single", WrEn, 0);
    settle(10);
    chk("wr_count", wr_cnt, 1);
    chk("wr_rd_count", rd_cnt, 0);
    chk("wr_tx_count", tx_cnt, ACK);
    chk("addr_hold", Address, 5);
    chk("wrdata_hold", WrData, 8'h3C);

    // Read frame BB,05 with exact TX timing
    base_tx = tx_cnt;
    send_byte(8'hBB);
    send_byte(8'h05);
    chk("rd_pulse", RdEn, 1);
    chk("rd_addr", Address, 5);
    chk("rd_no_wr", WrEn, 0);
    @(negedge CLK);
    chk("rd_single", RdEn, 0);
    chk("tx_not_yet", TX_D_VLD, 0);
    @(negedge CLK);
    chk("tx_vld", TX_D_VLD, 1);
    chk("tx_data", TX_P_DATA, 8'h3C);
    @(negedge CLK);
    chk("tx_single", TX_D_VLD, 0);
    chk("tx_data_stable", TX_P_DATA, 8'h3C);
    settle(8);
    chk("rd_tx_count", tx_cnt, base_tx + 1);

    // Read with TX_Busy held high for 20 cycles
    force_busy = 1'b1;
    base_tx = tx_cnt;
    send_byte(8'hBB);
    send_byte(8'h05);
    settle(20);
    chk("busy_no_tx", tx_cnt, base_tx);
    chk("busy_txvld_low", TX_D_VLD, 0);
    force_busy = 1'b0;
    wait_tx(base_tx + 1, "busy_release_tx");
    chk("busy_release_data", last_tx, 8'h3C);
    settle(8);
    chk("busy_release_single", tx_cnt, base_tx + 1);

    // Unknown command byte then a write
    base_err = err_cnt; base_wr = wr_cnt; base_rd = rd_cnt;
    send_byte(8'h12);
    chk("cmderr_pulse", Cmd_Err, 1);
    chk("cmderr_no_wr", WrEn, 0);
    chk("cmderr_no_rd", RdEn, 0);
    @(negedge CLK);
    chk("cmderr_single", Cmd_Err, 0);
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h81);
    chk("wr2_pulse", WrEn, 1);
    chk("wr2_addr", Address, 2);
    chk("wr2_data", WrData, 8'h81);
    settle(10);
    chk("cmderr_count", err_cnt, base_err + 1);
    chk("wr2_count", wr_cnt, base_wr + 1);
    chk("wr2_rd_count", rd_cnt, base_rd);

    // Address masking and a byte dropped in RD_WAIT
    rd_lat = 4;
    base_tx = tx_cnt; base_err = err_cnt; base_wr = wr_cnt;
    send_byte(8'hBB);
    send_byte(8'hF7);
    chk("addr_mask", Address, 7);
    chk("rd3_pulse", RdEn, 1);
    send_byte(8'hAA);
    wait_tx(base_tx + 1, "rdwait_tx");
    chk("rdwait_data", last_tx, 8'h17);
    settle(8);
    rd_lat = 1;
    chk("rdwait_no_err", err_cnt, base_err);
    chk("rdwait_no_wr", wr_cnt, base_wr);
    send_byte(8'hAA);
    send_byte(8'h09);
    send_byte(8'h66);
    chk("post_rd_wr", WrEn, 1);
    chk("post_rd_addr", Address, 9);
    settle(10);

    // Reset mid-frame after AA,03
    send_byte(8'hAA);
    send_byte(8'h03);
    RST = 1'b0;
    #1;
    chk("arst_wren", WrEn, 0);
    chk("arst_rden", RdEn, 0);
    chk("arst_txvld", TX_D_VLD, 0);
    chk("arst_cmderr", Cmd_Err, 0);
    chk("arst_addr", Address, 0);
    chk("arst_wrdata", WrData, 0);
    chk("arst_txdata", TX_P_DATA, 0);
    settle(2);
    RST = 1'b1;
    settle(1);
    base_wr = wr_cnt; base_err = err_cnt;
    send_byte(8'h44);
    chk("arst_cmderr_pulse", Cmd_Err, 1);
    chk("arst_no_wr_now", WrEn, 0);
    settle(6);
    chk("arst_no_wr", wr_cnt, base_wr);
    chk("arst_err_count", err_cnt, base_err + 1);

`ifdef REG_CMD_WR_ACK_EN
    // Write echo
    base_tx = tx_cnt;
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h5A);
    chk("ack_wr_pulse", WrEn, 1);
    wait_tx(base_tx + 1, "ack_tx");
    chk("ack_data", last_tx, 8'h5A);
    settle(8);
`endif

    chk("never_both", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
